uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period; legal range 2..1024.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 tx_data  input  8  byte to transmit; sampled only on handshake.
REQ-005 tx_valid  input  1  producer asserts when tx_data holds a valid byte.
REQ-006 tx_ready  output  1  block can accept a byte this cycle.
REQ-007 parallel_frame  output  10  frame for the downstream 10-bit parallel-to-serial register (LSB shifted first).
REQ-008 load_enable  output  1  one-cycle pulse loading parallel_frame into the downstream register.
REQ-009 shift_enable  output  1  one-cycle pulse advancing the downstream register by one bit.
REQ-010 tx_busy  output  1  frame in progress.
REQ-011 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 The block SHALL implement FSM states IDLE, LOAD, SEND, DONE.
REQ-013 A handshake SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data is captured and IDLE->LOAD.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_valid outside IDLE is ignored and no data is captured.
REQ-015 parallel_frame SHALL be registered as {1'b1, captured_byte[7:0], 1'b0}: bit0 start (0), bits8:1 data LSB first, bit9 stop (1).
REQ-016 parallel_frame SHALL hold its value until the next handshake.
REQ-017 In LOAD (cycle L), load_enable SHALL be 1 for exactly one cycle; the bit-period counter and bit counter clear to 0; LOAD->SEND.
REQ-018 In SEND, a bit-period counter (width ceil(log2(CLKS_PER_BIT))) SHALL increment every cycle and wrap to 0 after CLKS_PER_BIT-1.
REQ-019 shift_enable SHALL be 1 in cycles L+k*CLKS_PER_BIT, k=1..10, and 0 in all other cycles, giving each of the 10 bits exactly CLKS_PER_BIT cycles on the serial line.
REQ-020 A 4-bit bit counter SHALL increment on each shift_enable; on the 10th shift (count 9->10), SEND->DONE.
REQ-021 In DONE (cycle L+10*CLKS_PER_BIT+1), frame_done SHALL be 1 for one cycle; DONE->IDLE unconditionally.
REQ-022 tx_busy SHALL be 1 in LOAD, SEND, DONE; 0 in IDLE.
REQ-023 load_enable and shift_enable SHALL never be 1 in the same cycle.
REQ-024 Back-to-back: with tx_valid held high, the next handshake SHALL occur in the first IDLE cycle after DONE; minimum frame-to-frame interval is 10*CLKS_PER_BIT+3 cycles.
REQ-025 tx_data changes while busy SHALL not affect parallel_frame or the frame in progress.

Reset
REQ-026 While n_rst=0, independent of clk: state=IDLE, counters=0, parallel_frame=10'h3FF, load_enable=0, shift_enable=0, tx_busy=0, frame_done=0, tx_ready=0.
REQ-027 tx_ready SHALL be 1 from the first rising edge after n_rst deasserts.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no further load_enable, shift_enable or frame_done pulses.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Single byte: tx_data=8'hA5, tx_valid pulse in IDLE -> parallel_frame=10'h34A, load_enable 1 cycle later, shift_enable exactly 10 pulses spaced 4 cycles, frame_done at L+41, tx_ready back at L+42.
REQ-030 Serial check: downstream register (NUM_BITS=10, LSB-first, ones fill) -> line shows 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, then stays 1.
REQ-031 Back-to-back: tx_valid held high with 8'h00 then 8'hFF -> frames 10'h200 and 10'h3FE, second load_enable exactly 43 cycles after the first.
REQ-032 Busy ignore: toggle tx_valid and tx_data=8'h3C during SEND -> no handshake, parallel_frame unchanged, still 10 shifts.
REQ-033 Mid-frame reset: assert n_rst=0 after 5th shift_enable -> all outputs at reset values asynchronously, no frame_done; after release, a new byte transmits normally.
REQ-034 Parameter sweep: CLKS_PER_BIT=2 and 1024 -> shift spacing equals CLKS_PER_BIT, frame_done at L+10*CLKS_PER_BIT+1.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: captures a byte on handshake, builds a 10-bit frame and
// paces the load/shift pulses for an external LSB-first parallel-to-serial register.
//
// state | meaning
// IDLE  | ready for a byte (after the first clock out of reset)
// LOAD  | one-cycle load pulse, counters cleared
// SEND  | one shift pulse per CLKS_PER_BIT cycles, ten bits total
// DONE  | one-cycle completion pulse, then back to IDLE
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [9:0] parallel_frame,
  output logic       load_enable,
  output logic       shift_enable,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_tmr;
  logic [3:0]       bit_cnt;
  logic             ready_en;
  logic             bit_end;
  logic             handshake;

  assign bit_end   = (bit_tmr == CNT_LAST);
  assign handshake = (state == IDLE) && ready_en && tx_valid;

  always_comb begin
    state_nxt    = state;
    tx_ready     = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    tx_busy      = 1'b1;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        tx_busy  = 1'b0;
        tx_ready = ready_en;
        if (handshake) state_nxt = LOAD;
      end
      LOAD: begin
        load_enable = 1'b1;
        state_nxt   = SEND;
      end
      SEND: begin
        shift_enable = bit_end;
        if (bit_end && (bit_cnt == 4'd9)) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ready_en keeps tx_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      ready_en       <= 1'b0;
      parallel_frame <= 10'h3FF;
      bit_tmr        <= '0;
      bit_cnt        <= 4'd0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (handshake) parallel_frame <= {1'b1, tx_data, 1'b0};
      case (state)
        LOAD: begin
          bit_tmr <= '0;
          bit_cnt <= 4'd0;
        end
        SEND: begin
          bit_tmr <= bit_end ? '0 : bit_tmr + 1'b1;
          if (bit_end) bit_cnt <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
